dualport_ram_pipe: RTL and testbench
====================================

DUALPORT_RAM_PIPE -- requirements
Module: dualport_ram_pipe

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the data word width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 4, giving the address width; DEPTH = 2**ADDR_W.
REQ-003 The block SHALL have parameter RD_LAT, default 1, legal values 1 or 2, giving read latency in clocks.
REQ-004 The block SHALL have a single clock and an asynchronous, active-high reset.
REQ-005 Port clk, input, 1: sole clock; all state changes on the rising edge.
REQ-006 Port rst, input, 1: asynchronous, active-high reset.
REQ-007 Port data_in, input, DATA_W: write data.
REQ-008 Port wr_addr, input, ADDR_W: write address.
REQ-009 Port write, input, 1: write request, sampled each rising edge.
REQ-010 Port rd_addr, input, ADDR_W: read address.
REQ-011 Port read, input, 1: read request, sampled each rising edge.
REQ-012 Port clr, input, 1: request a full memory clear.
REQ-013 Port data_out, output, DATA_W: read data.
REQ-014 Port rd_valid, output, 1: data_out carries the result of an accepted read this cycle.
REQ-015 Port busy, output, 1: clear sequence in progress; requests are ignored.
REQ-016 Port collision, output, 1: one-cycle pulse flagging an accepted same-address read and write.

Function
REQ-017 The controller SHALL be a two-state FSM: CLEAR and READY.
REQ-018 In CLEAR, a counter SHALL write 0 to address 0, 1, ... DEPTH-1, one per clock, then enter READY on the edge after writing DEPTH-1; busy SHALL be 1 throughout CLEAR.
REQ-019 In READY, clr=1 SHALL enter CLEAR with the counter at 0; clr SHALL be ignored while in CLEAR.
REQ-020 A write SHALL be accepted when write=1 and state=READY; data_in is stored at wr_addr on that edge.
REQ-021 A read SHALL be accepted when read=1 and state=READY.
REQ-022 For a read accepted at edge N, data_out and rd_valid=1 SHALL appear after edge N+RD_LAT-1, i.e. visible in the cycle following edge N for RD_LAT=1.
REQ-023 rd_valid SHALL be 0 in every cycle with no accepted read at the corresponding edge; data_out SHALL hold its last value when rd_valid=0.
REQ-024 On an accepted read and write in the same cycle with rd_addr==wr_addr, the read SHALL return the new data_in (write-first), and collision SHALL be 1 for exactly one cycle, aligned with rd_valid.
REQ-025 Simultaneous read and write to different addresses SHALL both complete, and collision SHALL stay 0.
REQ-026 read or write asserted while busy=1 SHALL be dropped silently, with no memory change, no rd_valid, and no later replay.
REQ-027 Reads already in the RD_LAT=2 pipeline when clr is accepted SHALL still complete, returning pre-clear data.
REQ-028 Address arithmetic SHALL be unsigned ADDR_W bits; the clear counter SHALL be ADDR_W+1 bits so that termination is detected without wrap-around.

Reset
REQ-029 While rst=1, state SHALL be CLEAR with counter 0, busy=1, rd_valid=0, collision=0, data_out=0, and the read pipeline empty.
REQ-030 Deassertion of rst SHALL begin the clear sequence at address 0; DEPTH clocks later busy SHALL fall.
REQ-031 rst asserted mid-clear or mid-read SHALL abort immediately; in-flight reads SHALL be discarded and the clear restarts from 0.

Structure
REQ-032 Package dp_ram_pkg SHALL hold the state enum (CLEAR, READY) and the default values of DATA_W, ADDR_W and RD_LAT.
REQ-033 Sub-module dp_ram_core SHALL contain the storage array, the write-first bypass and the RD_LAT read pipeline; dualport_ram_pipe SHALL contain the FSM, the clear counter and the request gating.

Verification
REQ-034 Reset, then release: busy=1 for exactly 16 clocks, then 0; reading addresses 0..15 returns 0x00 at each.
REQ-035 Write 0xA5 to address 3, then read address 3 at RD_LAT=1 and at RD_LAT=2: data_out=0xA5 with rd_valid after 1 and 2 clocks respectively.
REQ-036 Same-cycle write 0x3C to address 7 and read of address 7: data_out=0x3C, rd_valid=1 and collision=1 for one cycle; a different-address pair gives collision=0.
REQ-037 Write 0xFF to address 15, pulse clr, issue a write to address 2 while busy: after the clear, address 15 reads 0x00, address 2 reads 0x00, and no rd_valid appears during busy.
REQ-038 Assert rst at clear count 5, release it: busy lasts a further full 16 clocks, and data_out=0 and rd_valid=0 during reset.
REQ-039 Run 500 random read/write transactions after the clear, checked against a reference model: zero mismatches, and every accepted read yields exactly one rd_valid.

Source files
------------

// File: rtl/dp_ram_pkg.sv
// Shared types and default geometry for the pipelined dual-port RAM.
package dp_ram_pkg;

  localparam int DP_DATA_W = 8;
  localparam int DP_ADDR_W = 4;
  localparam int DP_RD_LAT = 1;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } dp_state_t;

endpackage

// File: rtl/dualport_ram_pipe_if.sv
// Request/response bundle of the pipelined dual-port RAM; state is exported for observation.
interface dualport_ram_pipe_if
  import dp_ram_pkg::*;
#(
  parameter int DATA_W = DP_DATA_W,
  parameter int ADDR_W = DP_ADDR_W
);

  logic [DATA_W-1:0] data_in;
  logic [ADDR_W-1:0] wr_addr;
  logic              write;
  logic [ADDR_W-1:0] rd_addr;
  logic              read;
  logic              clr;
  logic [DATA_W-1:0] data_out;
  logic              rd_valid;
  logic              busy;
  logic              collision;
  dp_state_t         state;

  // No backpressure: a request is taken on any rising edge where busy is low,
  // and every taken read produces exactly one rd_valid cycle RD_LAT clocks later.
  modport master (
    output data_in, wr_addr, write, rd_addr, read, clr,
    input  data_out, rd_valid, busy, collision, state
  );

  modport slave (
    input  data_in, wr_addr, write, rd_addr, read, clr,
    output data_out, rd_valid, busy, collision, state
  );

endinterface

// File: rtl/dp_ram_core.sv
// Storage array with write-first bypass and a 1- or 2-stage registered read path.
module dp_ram_core
  import dp_ram_pkg::*;
#(
  parameter int DATA_W = DP_DATA_W,
  parameter int ADDR_W = DP_ADDR_W,
  parameter int RD_LAT = DP_RD_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              coll
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic              hit;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] s1_data;
  logic              s1_valid;
  logic              s1_coll;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign hit     = we && re && (waddr == raddr);
  assign rd_word = hit ? wdata : mem[raddr];

  // Read data is captured at the accepting edge, so later clears cannot disturb it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_data  <= '0;
      s1_valid <= 1'b0;
      s1_coll  <= 1'b0;
    end else begin
      s1_valid <= re;
      s1_coll  <= hit;
      if (re) s1_data <= rd_word;
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic [DATA_W-1:0] s2_data;
      logic              s2_valid;
      logic              s2_coll;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s2_data  <= '0;
          s2_valid <= 1'b0;
          s2_coll  <= 1'b0;
        end else begin
          s2_valid <= s1_valid;
          s2_coll  <= s1_coll;
          if (s1_valid) s2_data <= s1_data;
        end
      end

      assign rdata  = s2_data;
      assign rvalid = s2_valid;
      assign coll   = s2_coll;
    end else begin : g_lat1
      assign rdata  = s1_data;
      assign rvalid = s1_valid;
      assign coll   = s1_coll;
    end
  endgenerate

endmodule

// File: rtl/dualport_ram_pipe.sv
// Dual-port RAM top: CLEAR/READY controller, clear counter and request gating.
module dualport_ram_pipe
  import dp_ram_pkg::*;
#(
  parameter int DATA_W = DP_DATA_W,
  parameter int ADDR_W = DP_ADDR_W,
  parameter int RD_LAT = DP_RD_LAT
) (
  input logic                clk,
  input logic                rst,
  dualport_ram_pipe_if.slave bus
);

  localparam logic [ADDR_W:0] CNT_END = (ADDR_W + 1)'(2 ** ADDR_W);

  dp_state_t         state;
  dp_state_t         state_nxt;
  logic [ADDR_W:0]   clr_cnt;
  logic              clr_done;
  logic              busy;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              re;

  // The extra counter bit lets the last address be detected without wrapping to 0.
  assign clr_done = (clr_cnt + 1'b1) == CNT_END;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= (state == CLEAR) ? clr_cnt + 1'b1 : '0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:   if (clr_done) state_nxt = READY;
      READY:   if (bus.clr)  state_nxt = CLEAR;
      default: state_nxt = CLEAR;
    endcase
  end

  // While clearing, the write port is owned by the counter and user requests are dropped.
  always_comb begin
    busy  = (state == CLEAR);
    we    = busy | bus.write;
    waddr = busy ? clr_cnt[ADDR_W-1:0] : bus.wr_addr;
    wdata = busy ? '0 : bus.data_in;
    re    = bus.read & ~busy;
  end

  assign bus.busy  = busy;
  assign bus.state = state;

  dp_ram_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .RD_LAT (RD_LAT)
  ) u_core (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .re     (re),
    .raddr  (bus.rd_addr),
    .rdata  (bus.data_out),
    .rvalid (bus.rd_valid),
    .coll   (bus.collision)
  );

endmodule

// File: tb/tb_dualport_ram_pipe.sv
// Bench: one RD_LAT=1 and one RD_LAT=2 instance driven identically, checked against an array model.
module tb_dualport_ram_pipe;
  import dp_ram_pkg::*;

  localparam int W = 41;  // {expected cycle[31:0], collision, data[7:0]}

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  dualport_ram_pipe_if bus1 ();
  dualport_ram_pipe_if bus2 ();

  dualport_ram_pipe #(.DATA_W(8), .ADDR_W(4), .RD_LAT(1)) u_dut1 (
    .clk (clk), .rst (rst), .bus (bus1.slave)
  );
  dualport_ram_pipe #(.DATA_W(8), .ADDR_W(4), .RD_LAT(2)) u_dut2 (
    .clk (clk), .rst (rst), .bus (bus2.slave)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // reference model
  logic [7:0]   mem [16];
  int           clr_left = 0;
  logic [W-1:0] exp_q1[$];
  logic [W-1:0] exp_q2[$];
  logic [7:0]   last1 = '0;
  logic [7:0]   last2 = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input logic w, input logic [3:0] wa, input logic [7:0] wd,
                       input logic r, input logic [3:0] ra, input logic c);
    bus1.write = w;  bus1.wr_addr = wa; bus1.data_in = wd;
    bus1.read  = r;  bus1.rd_addr = ra; bus1.clr = c;
    bus2.write = w;  bus2.wr_addr = wa; bus2.data_in = wd;
    bus2.read  = r;  bus2.rd_addr = ra; bus2.clr = c;
  endtask

  // Called at a negedge; predicts the effect of the next rising edge, then moves to the next negedge.
  task automatic step(input logic w, input logic [3:0] wa, input logic [7:0] wd,
                      input logic r, input logic [3:0] ra, input logic c);
    logic [7:0] d;
    logic       col;
    chk("busy_lat1", bus1.busy, clr_left > 0);
    chk("busy_lat2", bus2.busy, clr_left > 0);
    chk("state_lat1", bus1.state == READY, clr_left == 0);
    drive(w, wa, wd, r, ra, c);
    if (clr_left == 0) begin
      if (r) begin
        col = w && (wa == ra);
        d   = col ? wd : mem[ra];
        exp_q1.push_back({32'(cyc + 1), col, d});
        exp_q2.push_back({32'(cyc + 2), col, d});
      end
      if (w) mem[wa] = wd;
      if (c) begin
        clr_left = 16;
        foreach (mem[i]) mem[i] = '0;
      end
    end else begin
      clr_left--;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    #1;
    rst = 1'b1;
    exp_q1.delete();
    exp_q2.delete();
    last1 = '0;
    last2 = '0;
    foreach (mem[i]) mem[i] = '0;
    drive(1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 1'b0);
    repeat (n) begin
      @(negedge clk);
      #1;
      chk("rst_data_lat1", bus1.data_out, 0);
      chk("rst_data_lat2", bus2.data_out, 0);
      chk("rst_valid_lat1", bus1.rd_valid, 0);
      chk("rst_valid_lat2", bus2.rd_valid, 0);
      chk("rst_coll_lat1", bus1.collision, 0);
      chk("rst_busy_lat2", bus2.busy, 1);
    end
    rst = 1'b0;
    clr_left = 16;
    mon_en = 1'b1;
  endtask

  // scoreboard monitor
  task automatic mon(input int k, input logic v, input logic [7:0] d, input logic c);
    logic [W-1:0] e;
    int           n;
    logic [7:0]   last;
    string        sfx;
    sfx  = (k == 0) ? "_lat1" : "_lat2";
    n    = (k == 0) ? exp_q1.size() : exp_q2.size();
    last = (k == 0) ? last1 : last2;
    if (v) begin
      if (n == 0) begin
        chk({"stray_valid", sfx}, v, 0);
      end else begin
        e = (k == 0) ? exp_q1.pop_front() : exp_q2.pop_front();
        chk({"latency", sfx}, cyc, e[40:9]);
        chk({"rdata", sfx}, d, e[7:0]);
        chk({"collision", sfx}, c, e[8]);
        if (k == 0) last1 = e[7:0]; else last2 = e[7:0];
      end
    end else begin
      chk({"hold", sfx}, d, last);
      chk({"coll_idle", sfx}, c, 0);
      if (n > 0) begin
        e = (k == 0) ? exp_q1[0] : exp_q2[0];
        if (int'(e[40:9]) <= cyc) begin
          chk({"missing_valid", sfx}, v, 1);
          if (k == 0) void'(exp_q1.pop_front()); else void'(exp_q2.pop_front());
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      mon(0, bus1.rd_valid, bus1.data_out, bus1.collision);
      mon(1, bus2.rd_valid, bus2.data_out, bus2.collision);
    end
  end

  // stimulus
  initial begin
    logic       w, r, c;
    logic [3:0] wa, ra;
    logic [7:0] wd;
    drive(1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 1'b0);
    @(negedge clk);
    do_reset(3);
    idle(18);

    // power-up contents are all zero
    for (int a = 0; a < 16; a++) step(1'b0, 4'd0, 8'd0, 1'b1, 4'(a), 1'b0);
    idle(2);

    // basic write then read, then write-first collision, then different-address pair
    step(1'b1, 4'd3, 8'hA5, 1'b0, 4'd0, 1'b0);
    step(1'b0, 4'd0, 8'd0, 1'b1, 4'd3, 1'b0);
    idle(2);
    step(1'b1, 4'd7, 8'h3C, 1'b1, 4'd7, 1'b0);
    idle(2);
    step(1'b1, 4'd8, 8'h11, 1'b1, 4'd3, 1'b0);
    idle(2);

    // clear with a read in flight, requests while busy are dropped
    step(1'b1, 4'd15, 8'hFF, 1'b0, 4'd0, 1'b0);
    step(1'b0, 4'd0, 8'd0, 1'b1, 4'd3, 1'b1);
    step(1'b1, 4'd2, 8'h55, 1'b0, 4'd0, 1'b0);
    step(1'b1, 4'd2, 8'h66, 1'b1, 4'd2, 1'b0);
    idle(15);
    step(1'b0, 4'd0, 8'd0, 1'b1, 4'd15, 1'b0);
    step(1'b0, 4'd0, 8'd0, 1'b1, 4'd2, 1'b0);
    step(1'b0, 4'd0, 8'd0, 1'b1, 4'd8, 1'b0);
    idle(2);

    // reset in the middle of a clear
    step(1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 1'b1);
    idle(5);
    do_reset(2);
    idle(17);

    // reset with a read in flight
    step(1'b1, 4'd4, 8'h42, 1'b0, 4'd0, 1'b0);
    step(1'b0, 4'd0, 8'd0, 1'b1, 4'd4, 1'b0);
    do_reset(2);
    idle(17);
    step(1'b0, 4'd0, 8'd0, 1'b1, 4'd4, 1'b0);
    idle(2);

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      w  = 1'($urandom_range(0, 1));
      r  = 1'($urandom_range(0, 1));
      wa = 4'($urandom_range(0, 15));
      ra = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
      wd = 8'($urandom_range(0, 255));
      c  = ($urandom_range(0, 79) == 0);
      step(w, wa, wd, r, ra, c);
    end
    idle(20);

    chk("drain_lat1", exp_q1.size(), 0);
    chk("drain_lat2", exp_q2.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
